// File: rtl/lm75_temp_poller_if.sv
// Request/result bundle between the LM75 poller and the I2C master it drives.
// The poller uses the master modport; the I2C master side uses the slave modport.
interface lm75_temp_poller_if;
    logic        mst_ready;
    logic        mst_start;
    logic        mst_rw;
    logic [6:0]  mst_slv_addr;
    logic [7:0]  mst_reg_addr;
    logic        mst_rd_valid;
    logic [15:0] mst_rd_data;
    logic        mst_nack;

    modport master (
        input  mst_ready, mst_rd_valid, mst_rd_data, mst_nack,
        output mst_start, mst_rw, mst_slv_addr, mst_reg_addr
    );

    modport slave (
        output mst_ready, mst_rd_valid, mst_rd_data, mst_nack,
        input  mst_start, mst_rw, mst_slv_addr, mst_reg_addr
    );
endinterface

// File: rtl/lm75_temp_poller.sv
// Periodic LM75 temperature reader: one 2-byte read of register 0x00 per poll
// interval, with min/max tracking, hysteretic over-temperature alarm and error count.
module lm75_temp_poller #(
    parameter int                POLL_CYCLES    = 1000000,
    parameter int                TIMEOUT_CYCLES = 200000,
    parameter logic [6:0]        SLV_ADDR       = 7'h48,
    parameter logic signed [8:0] T_OS           = 9'sd160,
    parameter logic signed [8:0] T_HYST         = 9'sd150
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    lm75_temp_poller_if.master  bus,
    output logic                busy,
    output logic [8:0]          temp_half,
    output logic                temp_valid,
    output logic [8:0]          temp_min,
    output logic [8:0]          temp_max,
    output logic                alarm,
    output logic [7:0]          err_count
);

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded on the start cycle so that the next start lands exactly POLL_CYCLES later.
    localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 2);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        UPDATE    = 3'd3,
        WAIT_POLL = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      poll_q, poll_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic signed [8:0]  sample_q, sample_d;
    logic signed [8:0]  temp_q, temp_d;
    logic               valid_q, valid_d;
    logic signed [8:0]  min_q, min_d;
    logic signed [8:0]  max_q, max_d;
    logic               alarm_q, alarm_d;
    logic               have_q, have_d;
    logic [7:0]         err_q, err_d;
    logic               unused_rd_lsbs;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v != 8'hFF) ? (v + 8'd1) : v;
    endfunction

    assign unused_rd_lsbs   = ^bus.mst_rd_data[6:0];
    assign bus.mst_start    = start_q;
    assign bus.mst_rw       = 1'b1;
    assign bus.mst_slv_addr = SLV_ADDR;
    assign bus.mst_reg_addr = 8'h00;
    assign busy             = busy_q;
    assign temp_half        = temp_q;
    assign temp_valid       = valid_q;
    assign temp_min         = min_q;
    assign temp_max         = max_q;
    assign alarm            = alarm_q;
    assign err_count        = err_q;

    // Next-state and datapath decode for the poll sequencer.
    always_comb begin
        state_d  = state_q;
        poll_d   = (poll_q != '0) ? (poll_q - PW'(1)) : poll_q;
        tmo_d    = (tmo_q != '0) ? (tmo_q - TW'(1)) : tmo_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        sample_d = sample_q;
        temp_d   = temp_q;
        valid_d  = 1'b0;
        min_d    = min_q;
        max_d    = max_q;
        alarm_d  = alarm_q;
        have_d   = have_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (bus.mst_ready) begin
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    poll_d  = POLL_LOAD;
                    tmo_d   = TMO_LOAD;
                    state_d = WAIT_DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_DONE: begin
                // NACK outranks a same-cycle read result.
                if (bus.mst_nack) begin
                    err_d   = sat_inc(err_q);
                    busy_d  = 1'b0;
                    state_d = WAIT_POLL;
                end else if (bus.mst_rd_valid) begin
                    sample_d = bus.mst_rd_data[15:7];
                    busy_d   = 1'b0;
                    state_d  = UPDATE;
                end else if (tmo_q == '0) begin
                    err_d   = sat_inc(err_q);
                    busy_d  = 1'b0;
                    state_d = WAIT_POLL;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            UPDATE: begin
                temp_d  = sample_q;
                valid_d = 1'b1;
                if (!have_q) begin
                    min_d  = sample_q;
                    max_d  = sample_q;
                    have_d = 1'b1;
                end else begin
                    min_d = (sample_q < min_q) ? sample_q : min_q;
                    max_d = (sample_q > max_q) ? sample_q : max_q;
                end
                if (sample_q >= T_OS) begin
                    alarm_d = 1'b1;
                end else if (sample_q < T_HYST) begin
                    alarm_d = 1'b0;
                end else begin
                    alarm_d = alarm_q;
                end
                state_d = WAIT_POLL;
            end
            WAIT_POLL: begin
                if (poll_q == '0) begin
                    state_d = enable ? ISSUE : IDLE;
                end else begin
                    state_d = WAIT_POLL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            poll_q   <= '0;
            tmo_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            sample_q <= 9'sd0;
            temp_q   <= 9'sd0;
            valid_q  <= 1'b0;
            min_q    <= 9'sd0;
            max_q    <= 9'sd0;
            alarm_q  <= 1'b0;
            have_q   <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            tmo_q    <= tmo_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            temp_q   <= temp_d;
            valid_q  <= valid_d;
            min_q    <= min_d;
            max_q    <= max_d;
            alarm_q  <= alarm_d;
            have_q   <= have_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lm75_temp_poller.sv
// Directed bench for lm75_temp_poller with short poll/timeout intervals.
module tb_lm75_temp_poller;
    localparam int POLL = 40;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       busy, temp_valid, alarm;
    logic [8:0] temp_half, temp_min, temp_max;
    logic [7:0] err_count;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = 0;
    int prev_start = 0;
    bit got;

    lm75_temp_poller_if bus();

    lm75_temp_poller #(
        .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .SLV_ADDR(7'h48),
        .T_OS(9'sd160), .T_HYST(9'sd150)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus),
        .busy(busy), .temp_half(temp_half), .temp_valid(temp_valid),
        .temp_min(temp_min), .temp_max(temp_max), .alarm(alarm), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int max_ticks, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_ticks && !found; i++) begin
            tick();
            if (bus.mst_start === 1'b1) begin
                found      = 1'b1;
                prev_start = last_start;
                last_start = cyc;
            end
        end
    endtask

    task automatic reply(input logic [15:0] d);
        bus.mst_rd_data  = d;
        bus.mst_rd_valid = 1'b1;
        tick();
        bus.mst_rd_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        bus.mst_ready = 1'b0; bus.mst_rd_valid = 1'b0; bus.mst_nack = 1'b0; bus.mst_rd_data = 16'h0000;
        repeat (3) tick();
        total++; if (bus.mst_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", bus.mst_start); end
        total++; if (bus.mst_rw !== 1'b1) begin bad++; $display("FAIL reset_rw got=%b exp=1", bus.mst_rw); end
        total++; if (bus.mst_slv_addr !== 7'h48) begin bad++; $display("FAIL reset_addr got=%h exp=48", bus.mst_slv_addr); end
        total++; if (bus.mst_reg_addr !== 8'h00) begin bad++; $display("FAIL reset_reg got=%h exp=00", bus.mst_reg_addr); end
        total++; if ({busy, temp_valid, alarm} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, temp_valid, alarm}); end
        total++; if ({temp_half, temp_min, temp_max, err_count} !== 35'd0) begin bad++; $display("FAIL reset_values got=%h/%h/%h/%h exp=0", temp_half, temp_min, temp_max, err_count); end
        rst = 1'b0;
    endtask

    task automatic test_first_sample();
        enable = 1'b1; bus.mst_ready = 1'b1;
        wait_start(10, got);
        total++; if (!got) begin bad++; $display("FAIL first_start got=none exp=pulse"); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", busy); end
        bus.mst_rd_data = 16'h1900; bus.mst_rd_valid = 1'b1;
        tick();
        bus.mst_rd_valid = 1'b0;
        total++; if (bus.mst_start !== 1'b0) begin bad++; $display("FAIL start_width got=%b exp=0", bus.mst_start); end
        total++; if (temp_valid !== 1'b0) begin bad++; $display("FAIL valid_early got=%b exp=0", temp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL first_busy_clr got=%b exp=0", busy); end
        tick();
        total++; if (temp_valid !== 1'b1) begin bad++; $display("FAIL valid_latency got=%b exp=1", temp_valid); end
        total++; if (temp_half !== 9'h032) begin bad++; $display("FAIL first_temp got=%h exp=032", temp_half); end
        total++; if (temp_min !== 9'h032 || temp_max !== 9'h032) begin bad++; $display("FAIL first_minmax got=%h/%h exp=032/032", temp_min, temp_max); end
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL first_alarm got=%b exp=0", alarm); end
        tick();
        total++; if (temp_valid !== 1'b0) begin bad++; $display("FAIL valid_width got=%b exp=0", temp_valid); end
    endtask

    task automatic test_minmax();
        // A stray result outside a transaction must be ignored.
        bus.mst_rd_data = 16'h7F80; bus.mst_rd_valid = 1'b1;
        tick();
        bus.mst_rd_valid = 1'b0;
        tick();
        total++; if (temp_valid !== 1'b0 || temp_half !== 9'h032) begin bad++; $display("FAIL stray_valid got=%b/%h exp=0/032", temp_valid, temp_half); end
        wait_start(60, got);
        total++; if (!got || last_start - prev_start != POLL) begin bad++; $display("FAIL spacing1 got=%0d exp=%0d", last_start - prev_start, POLL); end
        reply(16'h1980);
        total++; if (temp_half !== 9'd51 || temp_min !== 9'd50 || temp_max !== 9'd51) begin bad++; $display("FAIL sample51 got=%h/%h/%h exp=033/032/033", temp_half, temp_min, temp_max); end
        wait_start(60, got);
        total++; if (!got || last_start - prev_start != POLL) begin bad++; $display("FAIL spacing2 got=%0d exp=%0d", last_start - prev_start, POLL); end
        reply(16'hE700);
        total++; if (temp_half !== 9'h1CE || temp_min !== 9'h1CE || temp_max !== 9'd51) begin bad++; $display("FAIL sample_neg got=%h/%h/%h exp=1ce/1ce/033", temp_half, temp_min, temp_max); end
    endtask

    task automatic test_alarm();
        wait_start(60, got);
        reply(16'h5000);
        total++; if (!got || temp_half !== 9'd160 || alarm !== 1'b1) begin bad++; $display("FAIL alarm_set got=%h/%b exp=0a0/1", temp_half, alarm); end
        wait_start(60, got);
        reply(16'h4D00);
        total++; if (!got || temp_half !== 9'd154 || alarm !== 1'b1) begin bad++; $display("FAIL alarm_hold got=%h/%b exp=09a/1", temp_half, alarm); end
        wait_start(60, got);
        reply(16'h4A80);
        total++; if (!got || temp_half !== 9'd149 || alarm !== 1'b0) begin bad++; $display("FAIL alarm_clear got=%h/%b exp=095/0", temp_half, alarm); end
        total++; if (temp_max !== 9'd160) begin bad++; $display("FAIL alarm_max got=%h exp=0a0", temp_max); end
    endtask

    task automatic test_nack();
        int nvalid;
        nvalid = 0;
        wait_start(60, got);
        total++; if (!got) begin bad++; $display("FAIL nack_start got=none exp=pulse"); end
        bus.mst_nack = 1'b1; bus.mst_rd_valid = 1'b1; bus.mst_rd_data = 16'h7F80;
        tick();
        bus.mst_nack = 1'b0; bus.mst_rd_valid = 1'b0;
        total++; if (busy !== 1'b0 || err_count !== 8'd1) begin bad++; $display("FAIL nack_err got=%b/%0d exp=0/1", busy, err_count); end
        repeat (3) begin tick(); if (temp_valid === 1'b1) nvalid++; end
        total++; if (nvalid != 0 || temp_half !== 9'd149) begin bad++; $display("FAIL nack_nodata got=%0d/%h exp=0/095", nvalid, temp_half); end
        wait_start(60, got);
        total++; if (!got || last_start - prev_start != POLL) begin bad++; $display("FAIL nack_next got=%0d exp=%0d", last_start - prev_start, POLL); end
    endtask

    task automatic test_timeout();
        repeat (TMO - 1) tick();
        total++; if (busy !== 1'b1 || err_count !== 8'd1) begin bad++; $display("FAIL tmo_early got=%b/%0d exp=1/1", busy, err_count); end
        tick();
        total++; if (busy !== 1'b0 || err_count !== 8'd2) begin bad++; $display("FAIL tmo_exact got=%b/%0d exp=0/2", busy, err_count); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 298; i++) begin
            wait_start(60, got);
            if (!got) begin
                total++; bad++;
                $display("FAIL sat_start got=none exp=pulse at iteration %0d", i);
                break;
            end
        end
        repeat (TMO + 5) tick();
        total++; if (err_count !== 8'd255) begin bad++; $display("FAIL err_sat got=%0d exp=255", err_count); end
    endtask

    task automatic test_ready_low();
        int n;
        n = 0;
        bus.mst_ready = 1'b0;
        repeat (60) begin tick(); if (bus.mst_start === 1'b1) n++; end
        total++; if (n != 0 || busy !== 1'b0) begin bad++; $display("FAIL ready_low got=%0d/%b exp=0/0", n, busy); end
        bus.mst_ready = 1'b1;
        wait_start(2, got);
        total++; if (!got || busy !== 1'b1) begin bad++; $display("FAIL ready_high got=%b/%b exp=1/1", got, busy); end
    endtask

    task automatic test_enable_drop();
        int n;
        n = 0;
        enable = 1'b0;
        repeat (3) tick();
        reply(16'h1900);
        total++; if (temp_valid !== 1'b1 || temp_half !== 9'h032) begin bad++; $display("FAIL drop_capture got=%b/%h exp=1/032", temp_valid, temp_half); end
        repeat (3 * POLL) begin tick(); if (bus.mst_start === 1'b1) n++; end
        total++; if (n != 0 || busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%0d/%b exp=0/0", n, busy); end
    endtask

    task automatic test_rst_mid();
        enable = 1'b1;
        wait_start(10, got);
        repeat (3) tick();
        total++; if (!got || busy !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b/%b exp=1/1", got, busy); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if ({busy, temp_valid, alarm, bus.mst_start} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {busy, temp_valid, alarm, bus.mst_start}); end
        total++; if ({temp_half, temp_min, temp_max, err_count} !== 35'd0) begin bad++; $display("FAIL rst_values got=%h/%h/%h/%0d exp=0", temp_half, temp_min, temp_max, err_count); end
        tick();
        rst = 1'b0;
        wait_start(10, got);
        reply(16'hE700);
        total++; if (!got || temp_half !== 9'h1CE || temp_min !== 9'h1CE || temp_max !== 9'h1CE) begin bad++; $display("FAIL rst_first got=%h/%h/%h exp=1ce/1ce/1ce", temp_half, temp_min, temp_max); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_minmax();
        test_alarm();
        test_nack();
        test_timeout();
        test_saturation();
        test_ready_low();
        test_enable_drop();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
